// File: rtl/dec_input_key_if.sv
// Key-entry bus for dec_input_key: the serial key bit with its qualifier, plus the accept/mode status.
// The master drives the key; the slave (the decoder) returns Active and Mode.
interface dec_input_key_if;
    logic InputKey;
    logic ValidCmd;
    logic Active;
    logic Mode;

    modport master (
        output InputKey,
        output ValidCmd,
        input  Active,
        input  Mode
    );

    modport slave (
        input  InputKey,
        input  ValidCmd,
        output Active,
        output Mode
    );
endinterface

// File: rtl/dec_input_key.sv
// Serial "101" key detector (Moore FSM) with registered Active/Mode outputs.
// Optional macro DEC_INPUT_KEY_LOCK_EN latches DONE until Reset, ignoring ValidCmd drops.
module dec_input_key (
    input  logic           Clk,
    input  logic           Reset,
    dec_input_key_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t cs;
    state_t ns;

    always_comb begin
        ns = IDLE;
        case (cs)
            IDLE:    ns = bus.InputKey ? S1   : IDLE;
            S1:      ns = bus.InputKey ? S1   : S10;
            S10:     ns = bus.InputKey ? DONE : IDLE;
            DONE:    ns = DONE;
            default: ns = IDLE;
        endcase
        if (!bus.ValidCmd) begin
`ifdef DEC_INPUT_KEY_LOCK_EN
            ns = (cs == DONE) ? DONE : IDLE;
`else
            ns = IDLE;
`endif
        end
    end

    // Outputs are registered from ns so Active rises on the accepting edge itself.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cs         <= IDLE;
            bus.Active <= 1'b0;
            bus.Mode   <= 1'b0;
        end else begin
            cs         <= ns;
            bus.Active <= (ns == DONE);
            if (cs == DONE && bus.ValidCmd) begin
                bus.Mode <= bus.InputKey;
            end else if (ns != DONE) begin
                bus.Mode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dec_input_key.sv
// Directed bench for dec_input_key: key acceptance, overlap, abort, Mode capture and reset priority.
// Compile with DEC_INPUT_KEY_LOCK_EN to check the locked-DONE variant.
module tb_dec_input_key;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    dec_input_key_if bus ();

    dec_input_key dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step(input logic rst, input logic vc, input logic key);
        @(negedge Clk);
        Reset        = rst;
        bus.ValidCmd = vc;
        bus.InputKey = key;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic act, input logic md);
        chk({tag, ".cs"},     dut.cs,     st);
        chk({tag, ".Active"}, {1'b0, bus.Active}, {1'b0, act});
        chk({tag, ".Mode"},   {1'b0, bus.Mode},   {1'b0, md});
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        Reset        = 1'b1;
        bus.ValidCmd = 1'b0;
        bus.InputKey = 1'b0;

        // Reset held for two cycles, outputs stay cleared
        step(1, 0, 0); chk_all("rst1", 2'd0, 0, 0);
        step(1, 1, 1); chk_all("rst2", 2'd0, 0, 0);

        // Basic 1,0,1 acceptance
        step(0, 1, 1); chk_all("k101_e1", 2'd1, 0, 0);
        step(0, 1, 0); chk_all("k101_e2", 2'd2, 0, 0);
        step(0, 1, 1); chk_all("k101_e3", 2'd3, 1, 0);

        // Mode capture while in DONE
        step(0, 1, 0); chk_all("mode0", 2'd3, 1, 0);
        step(0, 1, 1); chk_all("mode1", 2'd3, 1, 1);

        // ValidCmd drop while in DONE
        step(0, 0, 0);
`ifdef DEC_INPUT_KEY_LOCK_EN
        chk_all("vc_drop_done", 2'd3, 1, 1);
`else
        chk_all("vc_drop_done", 2'd0, 0, 0);
`endif

        step(1, 0, 0); chk_all("rst3", 2'd0, 0, 0);

        // Overlap: 0,1,1,0,1
        step(0, 1, 0); chk("ovl_e1", dut.cs, 2'd0);
        step(0, 1, 1); chk("ovl_e2", dut.cs, 2'd1);
        step(0, 1, 1); chk("ovl_e3", dut.cs, 2'd1);
        step(0, 1, 0); chk_all("ovl_e4", 2'd2, 0, 0);
        step(0, 1, 1); chk_all("ovl_e5", 2'd3, 1, 0);

        step(1, 0, 0); chk_all("rst4", 2'd0, 0, 0);

        // Broken key: 1,0,0,1,0,1
        step(0, 1, 1); chk("brk_e1", dut.cs, 2'd1);
        step(0, 1, 0); chk("brk_e2", dut.cs, 2'd2);
        step(0, 1, 0); chk_all("brk_e3", 2'd0, 0, 0);
        step(0, 1, 1); chk("brk_e4", dut.cs, 2'd1);
        step(0, 1, 0); chk_all("brk_e5", 2'd2, 0, 0);
        step(0, 1, 1); chk_all("brk_e6", 2'd3, 1, 0);

        step(1, 0, 0); chk_all("rst5", 2'd0, 0, 0);

        // ValidCmd drop mid-sequence returns to IDLE
        step(0, 1, 1); chk("vc_mid_e1", dut.cs, 2'd1);
        step(0, 0, 0); chk_all("vc_mid_e2", 2'd0, 0, 0);

        // Reset in S10 with InputKey=1 beats the accepting transition
        step(0, 1, 1); chk("rs10_e1", dut.cs, 2'd1);
        step(0, 1, 0); chk("rs10_e2", dut.cs, 2'd2);
        step(1, 1, 1); chk_all("rs10_rst", 2'd0, 0, 0);
        step(0, 1, 1); chk_all("rs10_restart", 2'd1, 0, 0);

        // Reset while in DONE aborts acceptance
        step(0, 1, 0);
        step(0, 1, 1); chk_all("rdone_acc", 2'd3, 1, 0);
        step(0, 1, 1); chk("rdone_mode", {1'b0, bus.Mode}, 2'd1);
        step(1, 1, 1); chk_all("rdone_rst", 2'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
